i2c_read_arbiter: RTL

// - Shares one I2C 16-bit read engine between NUM_REQ requesters (e.g. temperature/accel pollers).
// - Round-robin arbitration, one-cycle engine start pulse, engine watchdog and enforced bus-free gap.
// - Returns the 16-bit result or an error code to the requester that was granted.
// - Sits between the sensor pollers and the single SCL/SDA read master, in the 200 kHz domain.

---
 rtl/i2c_read_arbiter_if.sv | 34 +++
 rtl/i2c_read_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/i2c_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// i2c_read_arbiter_if : requester and read-engine signal bundle for i2c_read_arbiter
// Rev 1.0
// ============================================================================
interface i2c_read_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_data;
  logic [1:0]           rsp_err;
  logic                 eng_start;
  logic [7:0]           eng_addr;
  logic                 eng_abort;
  logic                 eng_done;
  logic                 eng_nack;
  logic [15:0]          eng_data;

  // Arbiter side.
  modport master (
    input  req, req_addr, eng_done, eng_nack, eng_data,
    output grant, rsp_valid, rsp_data, rsp_err, eng_start, eng_addr, eng_abort
  );

  // Requesters and engine side.
  modport slave (
    output req, req_addr, eng_done, eng_nack, eng_data,
    input  grant, rsp_valid, rsp_data, rsp_err, eng_start, eng_addr, eng_abort
  );
endinterface
`default_nettype wire

// File: rtl/i2c_read_arbiter.sv
`default_nettype none
// ============================================================================
// i2c_read_arbiter : round-robin sharing of one 16-bit I2C read engine
// Rev 1.0
// ============================================================================
module i2c_read_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int GAP_CYC     = 20
) (
  input  logic               clk_200khz,
  input  logic               rst,
  i2c_read_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CND_W = IDX_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   win_q,   win_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [TMO_W-1:0]   tmo_q,   tmo_d;
  logic [GAP_W-1:0]   gap_q,   gap_d;
  logic [15:0]        data_q,  data_d;
  logic [1:0]         err_q,   err_d;
  logic [7:0]         addr_q,  addr_d;
  logic               abort_q, abort_d;

  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [CND_W-1:0]   cand;
  logic               busy;

  // First requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = CND_W'(ptr_q) + CND_W'(i);
      if (cand >= CND_W'(NUM_REQ)) begin
        cand = cand - CND_W'(NUM_REQ);
      end
      if (!pick_vld && bus.req[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    data_d  = data_q;
    err_d   = err_q;
    addr_d  = addr_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d   = pick;
          addr_d  = {bus.req_addr[7*int'(pick) +: 7], 1'b1};
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        // A completion arriving on the last allowed cycle beats the timeout.
        if (bus.eng_done) begin
          data_d  = bus.eng_data;
          err_d   = bus.eng_nack ? ERR_NACK : ERR_OK;
          state_d = ST_RESP;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          abort_d = 1'b1;
          data_d  = '0;
          err_d   = ERR_TMO;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_200khz or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      err_q   <= ERR_OK;
      addr_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
    end
  end

  assign busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_RESP);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign bus.grant[gi]     = busy && (win_q == IDX_W'(gi));
    assign bus.rsp_valid[gi] = (state_q == ST_RESP) && (win_q == IDX_W'(gi));
  end

  assign bus.eng_start = (state_q == ST_ISSUE);
  assign bus.eng_addr  = addr_q;
  assign bus.eng_abort = abort_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;

endmodule
`default_nettype wire
